// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and IF/ID handshake.
// master = fetch_unit, slave = the surrounding pipeline/memory.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, combinational imem access, IF/ID register, halt detect.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0000_006F
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       bus,
  output logic [31:0]        fetch_count,
  output logic               halted,
  output logic               fetch_misaligned
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] idpc4_q, idpc4_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        misal_q, misal_d;

  logic        redir_go;
  logic        trap_go;
  logic        blocked;
  logic        stall;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Once trapped, redirects are ignored and fetching stays frozen until reset.
  assign trap_go  = bus.redirect_valid && !misal_q && (bus.redirect_pc[1:0] != 2'b00);
  assign redir_go = bus.redirect_valid && !misal_q && (bus.redirect_pc[1:0] == 2'b00);
  assign blocked  = misal_q;
`else
  assign trap_go  = 1'b0;
  assign redir_go = bus.redirect_valid;
  assign blocked  = 1'b0;
`endif

  assign stall = (state_q == FULL) && !bus.id_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    idpc_d   = idpc_q;
    idpc4_d  = idpc4_q;
    count_d  = count_q;
    halted_d = halted_q;
    misal_d  = misal_q;

    if (redir_go) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      state_d = EMPTY;
      instr_d = NOP_INSTR;
    end else if (trap_go) begin
      misal_d = 1'b1;
      state_d = EMPTY;
      instr_d = NOP_INSTR;
    end else if (!(blocked || stall)) begin
      instr_d = bus.imem_instr;
      idpc_d  = pc_q;
      idpc4_d = pc_q + 32'd4;
      pc_d    = pc_q + 32'd4;
      state_d = FULL;
      count_d = (count_q == '1) ? count_q : count_q + 32'd1;
      if (bus.imem_instr == HALT_INSTR) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      idpc_q   <= '0;
      idpc4_q  <= 32'd4;
      count_q  <= '0;
      halted_q <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      idpc_q   <= idpc_d;
      idpc4_q  <= idpc4_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      misal_q  <= misal_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = (state_q == FULL);
  assign bus.id_instr    = instr_q;
  assign bus.id_pc       = idpc_q;
  assign bus.id_pc_plus4 = idpc4_q;
  assign fetch_count     = count_q;
  assign halted          = halted_q;
  assign fetch_misaligned = misal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a 64-word aliasing instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_count;
  logic        halted;
  logic        fetch_misaligned;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .fetch_count      (fetch_count),
    .halted           (halted),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always_comb bus.imem_instr = mem[bus.imem_addr[7:2]];

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ip4;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        h;
  } vec_t;

  vec_t tv [21];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy, logic v,
                              logic [31:0] instr, logic [31:0] ipc, logic [31:0] ip4,
                              logic [31:0] addr, logic [31:0] cnt, logic h);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.v = v; t.instr = instr;
    t.ipc = ipc; t.ip4 = ip4; t.addr = addr; t.cnt = cnt; t.h = h;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [31:0] instr,
                             input logic [31:0] ipc, input logic [31:0] ip4,
                             input logic [31:0] addr, input logic [31:0] cnt,
                             input logic h, input logic mis);
    check({tag, ".id_valid"},    {31'd0, bus.id_valid}, {31'd0, v});
    check({tag, ".id_instr"},    bus.id_instr, instr);
    check({tag, ".id_pc"},       bus.id_pc, ipc);
    check({tag, ".id_pc_plus4"}, bus.id_pc_plus4, ip4);
    check({tag, ".imem_addr"},   bus.imem_addr, addr);
    check({tag, ".fetch_count"}, fetch_count, cnt);
    check({tag, ".halted"},      {31'd0, halted}, {31'd0, h});
    check({tag, ".misaligned"},  {31'd0, fetch_misaligned}, {31'd0, mis});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0140_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0031_2023;
    mem[5] = HALT;

    //           rst rv  rpc           rdy v   instr          ipc           ip4           addr          cnt  h
    tv[0]  = mk(1, 0, 32'h0,        1, 0, NOP,           32'h0,        32'h4,        32'h0,        0, 0);
    tv[1]  = mk(0, 0, 32'h0,        1, 1, 32'h00A00093,  32'h0,        32'h4,        32'h4,        1, 0);
    tv[2]  = mk(0, 0, 32'h0,        1, 1, 32'h01400113,  32'h4,        32'h8,        32'h8,        2, 0);
    tv[3]  = mk(0, 0, 32'h0,        0, 1, 32'h01400113,  32'h4,        32'h8,        32'h8,        2, 0);
    tv[4]  = mk(0, 0, 32'h0,        0, 1, 32'h01400113,  32'h4,        32'h8,        32'h8,        2, 0);
    tv[5]  = mk(0, 0, 32'h0,        0, 1, 32'h01400113,  32'h4,        32'h8,        32'h8,        2, 0);
    tv[6]  = mk(0, 0, 32'h0,        1, 1, 32'h002081B3,  32'h8,        32'hC,        32'hC,        3, 0);
    tv[7]  = mk(0, 0, 32'h0,        1, 1, 32'h00312023,  32'hC,        32'h10,       32'h10,       4, 0);
    tv[8]  = mk(0, 1, 32'h40,       0, 0, NOP,           32'hC,        32'h10,       32'h40,       4, 0);
    tv[9]  = mk(0, 0, 32'h0,        0, 1, 32'h10000010,  32'h40,       32'h44,       32'h44,       5, 0);
    tv[10] = mk(0, 1, 32'h14,       1, 0, NOP,           32'h40,       32'h44,       32'h14,       5, 0);
    tv[11] = mk(0, 0, 32'h0,        1, 1, HALT,          32'h14,       32'h18,       32'h18,       6, 1);
    tv[12] = mk(0, 1, 32'h14,       1, 0, NOP,           32'h14,       32'h18,       32'h14,       6, 1);
    tv[13] = mk(0, 0, 32'h0,        1, 1, HALT,          32'h14,       32'h18,       32'h18,       7, 1);
    tv[14] = mk(0, 1, 32'h8,        1, 0, NOP,           32'h14,       32'h18,       32'h8,        7, 1);
    tv[15] = mk(0, 0, 32'h0,        1, 1, 32'h002081B3,  32'h8,        32'hC,        32'hC,        8, 1);
    tv[16] = mk(1, 1, 32'h40,       0, 0, NOP,           32'h0,        32'h4,        32'h0,        0, 0);
    tv[17] = mk(0, 0, 32'h0,        1, 1, 32'h00A00093,  32'h0,        32'h4,        32'h4,        1, 0);
    tv[18] = mk(0, 1, 32'hFFFFFFFC, 1, 0, NOP,           32'h0,        32'h4,        32'hFFFFFFFC, 1, 0);
    tv[19] = mk(0, 0, 32'h0,        1, 1, 32'h1000003F,  32'hFFFFFFFC, 32'h0,        32'h0,        2, 0);
    tv[20] = mk(0, 0, 32'h0,        1, 1, 32'h00A00093,  32'h0,        32'h4,        32'h4,        3, 0);

    drive(1, 0, 32'h0, 1);
    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].rst, tv[i].rv, tv[i].rpc, tv[i].rdy);
      step();
      check_state($sformatf("v%0d", i), tv[i].v, tv[i].instr, tv[i].ipc, tv[i].ip4,
                  tv[i].addr, tv[i].cnt, tv[i].h, 1'b0);
      @(negedge clk);
    end

    // Misaligned redirect to 0x22 from pc=4, fetch_count=3.
    drive(0, 1, 32'h22, 1);
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check_state("mis0", 0, NOP, 32'h0, 32'h4, 32'h4, 3, 0, 1);
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    step();
    check_state("mis1", 0, NOP, 32'h0, 32'h4, 32'h4, 3, 0, 1);
    @(negedge clk);
    drive(0, 1, 32'h40, 1);
    step();
    check_state("mis2", 0, NOP, 32'h0, 32'h4, 32'h4, 3, 0, 1);
    @(negedge clk);
    drive(1, 0, 32'h0, 1);
    step();
    check_state("mis_rst", 0, NOP, 32'h0, 32'h4, 32'h0, 0, 0, 0);
`else
    check_state("mis0", 0, NOP, 32'h0, 32'h4, 32'h20, 3, 0, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    step();
    check_state("mis1", 1, 32'h10000008, 32'h20, 32'h24, 32'h24, 4, 0, 0);
    @(negedge clk);
    drive(1, 0, 32'h0, 1);
    step();
    check_state("mis_rst", 0, NOP, 32'h0, 32'h4, 32'h0, 0, 0, 0);
`endif

    // Saturation: preload the counter just below the top, then advance twice.
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    step();
    check("sat1.fetch_count", fetch_count, 32'hFFFF_FFFF);
    check("sat1.id_instr", bus.id_instr, 32'h00A0_0093);
    @(negedge clk);
    step();
    check("sat2.fetch_count", fetch_count, 32'hFFFF_FFFF);
    check("sat2.id_pc", bus.id_pc, 32'h4);
    @(negedge clk);
    step();
    check("sat3.fetch_count", fetch_count, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
